// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   Shares one single-port L2 SRAM between a JTAG debug bus and a core test
//   bus. Grants are combinational in the request cycle, arbitration is
//   round-robin on a 1-bit last-winner flag, and jtag_lock_i gives JTAG
//   exclusive access. Every grant returns exactly one response one cycle
//   later; accesses outside [L2_BASE, L2_BASE + 4*2^MEM_AW) never reach the
//   SRAM and answer with err = 1.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   jtag_* / core_* (requester)  req/addr/we/be/wdata in, gnt out,
//                                rvalid/rdata/err response out
//   jtag_lock_i                  JTAG-only access while high
//   mem_*                        SRAM strobe, we, word address, be, wdata;
//                                mem_rdata_i returns one cycle after mem_req_o
module l2_port_arbiter #(
  parameter logic [31:0] L2_BASE = 32'h1C00_0000,
  parameter int          MEM_AW  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jtag_req_i,
  output logic              jtag_gnt_o,
  input  logic [31:0]       jtag_addr_i,
  input  logic              jtag_we_i,
  input  logic [3:0]        jtag_be_i,
  input  logic [31:0]       jtag_wdata_i,
  output logic              jtag_rvalid_o,
  output logic [31:0]       jtag_rdata_o,
  output logic              jtag_err_o,
  input  logic              jtag_lock_i,
  input  logic              core_req_i,
  output logic              core_gnt_o,
  input  logic [31:0]       core_addr_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              core_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  // 33-bit window bounds so a window touching 2^32 cannot wrap.
  localparam logic [32:0] BASE33  = {1'b0, L2_BASE};
  localparam logic [32:0] LIMIT33 = BASE33 + (33'd4 << MEM_AW);

  logic        last_jtag_q, last_jtag_d;   // 1: JTAG won the latest grant
  logic        rvalid_jtag_q, rvalid_jtag_d;
  logic        rvalid_core_q, rvalid_core_d;
  logic        err_q, err_d;
  logic        rd_mem_q, rd_mem_d;         // response carries SRAM read data

  logic        jtag_gnt, core_gnt, any_gnt, in_range;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_we;

  // Grant decision; grants are forced low while reset is held.
  always_comb begin
    jtag_gnt = 1'b0;
    core_gnt = 1'b0;
    if (!rst_i) begin
      if (jtag_lock_i) begin
        jtag_gnt = jtag_req_i;
      end else if (jtag_req_i && core_req_i) begin
        jtag_gnt = ~last_jtag_q;
        core_gnt = last_jtag_q;
      end else begin
        jtag_gnt = jtag_req_i;
        core_gnt = core_req_i;
      end
    end
  end

  assign any_gnt   = jtag_gnt | core_gnt;
  assign sel_addr  = jtag_gnt ? jtag_addr_i  : core_addr_i;
  assign sel_we    = jtag_gnt ? jtag_we_i    : core_we_i;
  assign sel_be    = jtag_gnt ? jtag_be_i    : core_be_i;
  assign sel_wdata = jtag_gnt ? jtag_wdata_i : core_wdata_i;
  assign in_range  = any_gnt && ({1'b0, sel_addr} >= BASE33) && ({1'b0, sel_addr} < LIMIT33);

  assign jtag_gnt_o  = jtag_gnt;
  assign core_gnt_o  = core_gnt;

  // SRAM side is fully zeroed unless an in-range access is granted.
  assign mem_req_o   = in_range;
  assign mem_we_o    = in_range & sel_we;
  assign mem_be_o    = in_range ? sel_be    : 4'h0;
  assign mem_wdata_o = in_range ? sel_wdata : 32'h0;
  assign mem_addr_o  = in_range ? MEM_AW'((sel_addr - L2_BASE) >> 2) : '0;

  always_comb begin
    last_jtag_d   = any_gnt ? jtag_gnt : last_jtag_q;
    rvalid_jtag_d = jtag_gnt;
    rvalid_core_d = core_gnt;
    err_d         = any_gnt & ~in_range;
    rd_mem_d      = in_range & ~sel_we;
  end

  // Reset clears the response stage, dropping any in-flight response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_jtag_q   <= 1'b0;
      rvalid_jtag_q <= 1'b0;
      rvalid_core_q <= 1'b0;
      err_q         <= 1'b0;
      rd_mem_q      <= 1'b0;
    end else begin
      last_jtag_q   <= last_jtag_d;
      rvalid_jtag_q <= rvalid_jtag_d;
      rvalid_core_q <= rvalid_core_d;
      err_q         <= err_d;
      rd_mem_q      <= rd_mem_d;
    end
  end

  assign jtag_rvalid_o = rvalid_jtag_q;
  assign jtag_err_o    = rvalid_jtag_q & err_q;
  assign jtag_rdata_o  = (rvalid_jtag_q && rd_mem_q) ? mem_rdata_i : 32'h0;
  assign core_rvalid_o = rvalid_core_q;
  assign core_err_o    = rvalid_core_q & err_q;
  assign core_rdata_o  = (rvalid_core_q && rd_mem_q) ? mem_rdata_i : 32'h0;

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 The block SHALL have parameter L2_BASE, default 32'h1C00_0000, meaning the byte base address of L2.
REQ-002 The block SHALL have parameter MEM_AW, default 16, meaning the SRAM word-address width; L2 size is 4*2^MEM_AW bytes.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock; all state on its rising edge.
- rst_i  in  1  asynchronous active-high reset.
- jtag_req_i / core_req_i  in  1  request from the JTAG debug bus / core test bus.
- jtag_gnt_o / core_gnt_o  out  1  grant; request accepted this cycle.
- jtag_addr_i / core_addr_i  in  32  byte address.
- jtag_we_i / core_we_i  in  1  1 = write, 0 = read.
- jtag_be_i / core_be_i  in  4  byte enables.
- jtag_wdata_i / core_wdata_i  in  32  write data.
- jtag_rvalid_o / core_rvalid_o  out  1  response valid.
- jtag_rdata_o / core_rdata_o  out  32  read data.
- jtag_err_o / core_err_o  out  1  response error; qualified by rvalid.
- jtag_lock_i  in  1  while high, only JTAG is granted.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  MEM_AW  SRAM word address = (addr - L2_BASE)>>2.
- mem_be_o  out  4  SRAM byte enables.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data, valid exactly one cycle after mem_req_o.

Function
REQ-004 Grant SHALL be combinational in the request cycle; at most one of jtag_gnt_o, core_gnt_o SHALL be high per cycle.
REQ-005 Requesters SHALL hold req, addr, we, be and wdata stable until gnt; the block need not check this.
REQ-006 Arbitration SHALL be round-robin using a 1-bit last-winner register: on a conflict, the requester that did not win last SHALL be granted. The register SHALL update only on a grant.
REQ-007 While jtag_lock_i = 1, core_gnt_o SHALL be 0, and jtag_req_i SHALL be granted every cycle it is high.
REQ-008 A granted request SHALL be in range iff L2_BASE <= addr < L2_BASE + 4*2^MEM_AW, computed without 32-bit wrap (33-bit compare).
REQ-009 An in-range grant SHALL drive mem_req_o = 1 with we/be/wdata/addr forwarded in the same cycle. An out-of-range grant SHALL keep mem_req_o = 0.
REQ-010 Every grant (read or write, in or out of range) SHALL produce exactly one rvalid pulse to the granted requester exactly one cycle later. Owner and error are registered.
REQ-011 rdata_o SHALL equal mem_rdata_i for an in-range read and 32'h0 for writes or errors. err_o SHALL be 1 only for out-of-range. The non-owner's rvalid, err and rdata SHALL be 0.
REQ-012 Back-to-back grants SHALL be sustained, giving one access per cycle with no bubble, including alternating owners.
REQ-013 When no grant occurs, mem_req_o SHALL be 0 and mem_addr_o, mem_be_o, mem_wdata_o and mem_we_o SHALL be 0.
REQ-014 The address low bits [1:0] SHALL be ignored; byte selection SHALL be via be only.

Reset
REQ-015 While rst_i = 1, all outputs SHALL be 0, and the last-winner register SHALL reset so that JTAG wins the first conflict.
REQ-016 Assertion of rst_i SHALL discard any in-flight response, so no rvalid is issued for a grant in the cycle before reset. Operation SHALL resume on the first edge after deassertion.

Verification
REQ-017 Scenario 1: JTAG writes 32'hABBAABBA to L2_BASE with be = 4'hF, then reads L2_BASE. Required response: gnt in the same cycle each time, rvalid one cycle later, rdata = 32'hABBAABBA, err = 0.
REQ-018 Scenario 2: both requesters hold a request for 4 cycles after reset. Required response: grants are J, C, J, C, and each rvalid goes to the matching owner.
REQ-019 Scenario 3: jtag_lock_i = 1 with both requesting for 3 cycles. Required response: 3 JTAG grants, core_gnt_o = 0; after lock drops, core is granted next.
REQ-020 Scenario 4: core reads 32'h1C04_0000 (out of range with MEM_AW = 16). Required response: mem_req_o = 0, core_rvalid_o = 1 one cycle later with core_err_o = 1 and rdata = 0; also address 32'hFFFF_FFFC gives err = 1.
REQ-021 Scenario 5: byte write be = 4'b0010 of 32'h0000_5500 over 32'h1111_1111, then read back. Required response: 32'h1111_5511.
REQ-022 Scenario 6: JTAG read is granted, and rst_i pulses in the next cycle. Required response: no rvalid, all outputs 0 during reset, and the first post-reset conflict is won by JTAG.
